// File: rtl/mult_sched_4ch.sv
// mult_sched_4ch: shares one external pipelined multiplier among four request channels.
// Optional macro MULT_SCHED_ROUND_ROBIN_EN selects round-robin arbitration; fixed priority otherwise.
module mult_sched_4ch #(
  parameter int LATENCY = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   s_valid,
  output logic [3:0]   s_ready,
  input  logic [127:0] s_a,
  input  logic [127:0] s_b,
  output logic [31:0]  mult_a,
  output logic [31:0]  mult_b,
  input  logic [63:0]  mult_p,
  output logic         m_valid,
  output logic [1:0]   m_id,
  output logic [63:0]  m_dout,
  output logic         busy
);

  logic [31:0] ch_a [4];
  logic [31:0] ch_b [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign ch_a[gi] = s_a[32*gi +: 32];
      assign ch_b[gi] = s_b[32*gi +: 32];
    end
  endgenerate

  logic       grant_any;
  logic [1:0] grant_id;
  logic       accept;

`ifdef MULT_SCHED_ROUND_ROBIN_EN
  // Pointer holds the last granted channel; the search begins just after it.
  logic [1:0] rr_ptr_reg;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_any && s_valid[rr_ptr_reg + 2'(k)]) begin
        grant_any = 1'b1;
        grant_id  = rr_ptr_reg + 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= 2'd3;
    end else if (accept) begin
      rr_ptr_reg <= grant_id;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (s_valid[k]) begin
        grant_any = 1'b1;
        grant_id  = 2'(k);
      end
    end
  end
`endif

  assign accept  = grant_any & ~rst;
  assign s_ready = accept ? (4'b0001 << grant_id) : 4'b0000;

  logic [31:0] mult_a_reg;
  logic [31:0] mult_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mult_a_reg <= '0;
      mult_b_reg <= '0;
    end else if (accept) begin
      mult_a_reg <= ch_a[grant_id];
      mult_b_reg <= ch_b[grant_id];
    end
  end

  assign mult_a = mult_a_reg;
  assign mult_b = mult_b_reg;

  // Stage 0 lines up with the operands at the multiplier; stage LATENCY with mult_p.
  logic [LATENCY:0] vpipe_reg;
  logic [1:0]       idpipe_reg [LATENCY+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_reg <= '0;
    end else begin
      vpipe_reg <= {vpipe_reg[LATENCY-1:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idpipe_reg[0] <= grant_id;
    end
  end

  generate
    for (gi = 1; gi <= LATENCY; gi++) begin : g_idpipe
      always_ff @(posedge clk) begin
        idpipe_reg[gi] <= idpipe_reg[gi-1];
      end
    end
  endgenerate

  logic        m_valid_reg;
  logic [1:0]  m_id_reg;
  logic [63:0] m_dout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      m_id_reg    <= 2'd0;
      m_dout_reg  <= '0;
    end else begin
      m_valid_reg <= vpipe_reg[LATENCY];
      if (vpipe_reg[LATENCY]) begin
        m_id_reg   <= idpipe_reg[LATENCY];
        m_dout_reg <= mult_p;
      end
    end
  end

  assign m_valid = m_valid_reg;
  assign m_id    = m_id_reg;
  assign m_dout  = m_dout_reg;

  logic [3:0] pending_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 4'd0;
    end else begin
      case ({accept, m_valid_reg})
        2'b10:   pending_reg <= pending_reg + 4'd1;
        2'b01:   pending_reg <= pending_reg - 4'd1;
        default: pending_reg <= pending_reg;
      endcase
    end
  end

  assign busy = (pending_reg != 4'd0);

endmodule
